// File: rtl/rx_fifo_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rx_fifo_arbiter
//  Purpose  : Round-robin scheduler that shares one RX FIFO write port among
//             NUM_SRC DDC sources. Each source presents one I/Q pair per
//             strobe. The pair is latched and then written as two 16-bit
//             words, I first, each tagged with source id and I/Q flag.
//             Tracks per-source overrun and a saturating drop count.
//  Revision : 1.0  initial release
// ============================================================================
module rx_fifo_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic                    rxclk,
    input  logic                    reset,
    input  logic [NUM_SRC-1:0]      src_enable,
    input  logic [NUM_SRC-1:0]      src_strobe,
    input  logic [16*NUM_SRC-1:0]   src_i,
    input  logic [16*NUM_SRC-1:0]   src_q,
    input  logic                    fifo_full,
    output logic                    fifo_wrreq,
    output logic [15:0]             fifo_data,
    output logic [SRC_W-1:0]        fifo_src,
    output logic                    fifo_iq,
    input  logic                    clear_status,
    output logic [NUM_SRC-1:0]      overrun,
    output logic [15:0]             drop_count,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_I = 2'd1,
        WR_Q = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SRC_W-1:0]     grant_q, grant_d;
    logic [SRC_W-1:0]     last_grant_q, last_grant_d;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   overrun_q, overrun_d;
    logic [15:0]          drop_q, drop_d;
    logic [15:0]          ival_q [NUM_SRC];
    logic [15:0]          ival_d [NUM_SRC];
    logic [15:0]          qval_q [NUM_SRC];
    logic [15:0]          qval_d [NUM_SRC];

    logic                 q_write;
    logic [NUM_SRC-1:0]   req;
    logic [SRC_W-1:0]     rr_ptr;
    logic [SRC_W-1:0]     rr_idx;
    logic [SRC_W-1:0]     rr_pick;
    logic                 rr_found;
    logic [15:0]          n_drop;
    logic [15:0]          drop_base;
    logic [16:0]          drop_sum;

    // The Q word of the granted pair is accepted by the FIFO this cycle
    assign q_write = (state_q == WR_Q) && !fifo_full;

    // Round-robin pick: first requesting source after the pointer, wrapping.
    // In WR_Q the current grant is excluded so a pair is never re-granted
    // back-to-back, and the pointer is the grant being retired.
    always_comb begin
        req      = pending_q & src_enable;
        rr_ptr   = last_grant_q;
        rr_idx   = '0;
        rr_pick  = '0;
        rr_found = 1'b0;
        if (state_q == WR_Q) begin
            req[grant_q] = 1'b0;
            rr_ptr       = grant_q;
        end
        for (int i = 1; i <= NUM_SRC; i++) begin
            rr_idx = SRC_W'((int'(rr_ptr) + i) % NUM_SRC);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    // Scheduler next-state: a stalled FIFO freezes the FSM in place
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_d = rr_pick;
                    state_d = WR_I;
                end
            end
            WR_I: begin
                if (!fifo_full) begin
                    state_d = WR_Q;
                end
            end
            WR_Q: begin
                if (!fifo_full) begin
                    last_grant_d = grant_q;
                    if (rr_found) begin
                        grant_d = rr_pick;
                        state_d = WR_I;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO write-side decode; data/id hold steady while stalled on full
    always_comb begin
        busy       = (state_q != IDLE);
        fifo_wrreq = busy && !fifo_full;
        fifo_iq    = (state_q == WR_I);
        fifo_src   = busy ? grant_q : '0;
        fifo_data  = 16'h0000;
        if (state_q == WR_I) begin
            fifo_data = ival_q[grant_q];
        end else if (state_q == WR_Q) begin
            fifo_data = qval_q[grant_q];
        end
    end

    // Per-source capture, overrun detection and status counters
    always_comb begin
        pending_d = pending_q;
        overrun_d = clear_status ? '0 : overrun_q;
        n_drop    = 16'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            ival_d[k] = ival_q[k];
            qval_d[k] = qval_q[k];
            if (src_enable[k]) begin
                if (q_write && (grant_q == SRC_W'(k))) begin
                    pending_d[k] = 1'b0;
                end
                if (src_strobe[k]) begin
                    // A slot being released this cycle can take the new sample
                    if (!pending_q[k] || (q_write && (grant_q == SRC_W'(k)))) begin
                        ival_d[k]    = src_i[16*k +: 16];
                        qval_d[k]    = src_q[16*k +: 16];
                        pending_d[k] = 1'b1;
                    end else begin
                        overrun_d[k] = 1'b1;
                        n_drop       = n_drop + 16'd1;
                    end
                end
            end else begin
                // A disabled source keeps its slot only while its pair is in flight
                if ((state_q == IDLE) || (grant_q != SRC_W'(k)) || q_write) begin
                    pending_d[k] = 1'b0;
                end
            end
        end
        drop_base = clear_status ? 16'd0 : drop_q;
        drop_sum  = {1'b0, drop_base} + {1'b0, n_drop};
        drop_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Control and status registers
    always_ff @(posedge rxclk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_W'(NUM_SRC - 1);
            pending_q    <= '0;
            overrun_q    <= '0;
            drop_q       <= 16'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            drop_q       <= drop_d;
        end
    end

    // Sample hold registers; only meaningful while the matching pending bit is set
    always_ff @(posedge rxclk) begin
        for (int k = 0; k < NUM_SRC; k++) begin
            ival_q[k] <= ival_d[k];
            qval_q[k] <= qval_d[k];
        end
    end

    assign overrun    = overrun_q;
    assign drop_count = drop_q;

endmodule
`default_nettype wire
